mem_ctrl: RTL and testbench

Bridges the single-cycle memory port of `cpu` to an Avalon-MM style memory with wait states and variable read latency. Sits directly downstream of `cpu`. Each CPU access is captured, issued on the bus, and the CPU is stalled until completion. A watchdog terminates hung transactions and raises a sticky error.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/wdt_counter.sv | 38 +++
 rtl/mem_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the CPU-to-Avalon memory bridge.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DONE
    } mem_state_t;

    localparam logic [15:0] TIMEOUT_RDDATA = 16'hDEAD;
    localparam int          BYTE_AW        = 16;
    localparam int          WORD_AW        = 15;

endpackage

// File: rtl/wdt_counter.sv
// Saturating transaction watchdog; expired is high once TIMEOUT_CYCLES
// enabled cycles have elapsed since the last clear.
module wdt_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (en && cnt != LIMIT)
            cnt_nxt = cnt + 1'b1;
    end

    // expired tracks the count so the FSM sees it in the cycle the limit is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            expired <= (cnt_nxt == LIMIT);
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Bridges the single-cycle CPU memory port to an Avalon-MM bus with wait
// states and variable read latency; stalls the CPU until each access ends.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_AW-1:0]  i_cpu_addr,
    input  logic                i_cpu_rd,
    input  logic                i_cpu_wr,
    input  logic [15:0]         i_cpu_wrdata,
    output logic [15:0]         o_cpu_rddata,
    output logic                o_cpu_stall,
    output logic [WORD_AW-1:0]  o_avm_address,
    output logic                o_avm_read,
    output logic                o_avm_write,
    output logic [15:0]         o_avm_writedata,
    input  logic [15:0]         i_avm_readdata,
    input  logic                i_avm_readdatavalid,
    input  logic                i_avm_waitrequest,
    output logic                o_err,
    input  logic                i_err_clr
);

    mem_state_t  state, state_nxt;
    logic        is_wr;
    logic        capture;
    logic        expired;
    logic        rd_load;
    logic [15:0] rd_val;
    logic        err_set;

    assign capture = (state == IDLE) && (i_cpu_rd || i_cpu_wr);

    wdt_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .reset  (reset),
        .clr    (capture),
        .en     ((state == REQ) || (state == WAIT_DATA)),
        .expired(expired)
    );

    always_comb begin
        state_nxt   = state;
        rd_load     = 1'b0;
        rd_val      = i_avm_readdata;
        err_set     = 1'b0;
        o_avm_read  = 1'b0;
        o_avm_write = 1'b0;
        o_cpu_stall = capture || (state == REQ) || (state == WAIT_DATA);
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = REQ;
                    err_set   = i_cpu_addr[0];
                end
            end
            REQ: begin
                // a timeout outranks acceptance: strobes are already withdrawn
                if (expired) begin
                    state_nxt = DONE;
                    err_set   = 1'b1;
                    rd_load   = !is_wr;
                    rd_val    = TIMEOUT_RDDATA;
                end else begin
                    o_avm_write = is_wr;
                    o_avm_read  = !is_wr;
                    if (!i_avm_waitrequest) begin
                        if (is_wr) begin
                            state_nxt = DONE;
                        end else if (i_avm_readdatavalid) begin
                            state_nxt = DONE;
                            rd_load   = 1'b1;
                        end else begin
                            state_nxt = WAIT_DATA;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                if (expired) begin
                    state_nxt = DONE;
                    err_set   = 1'b1;
                    rd_load   = 1'b1;
                    rd_val    = TIMEOUT_RDDATA;
                end else if (i_avm_readdatavalid) begin
                    state_nxt = DONE;
                    rd_load   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            is_wr           <= 1'b0;
            o_avm_address   <= '0;
            o_avm_writedata <= '0;
            o_cpu_rddata    <= '0;
            o_err           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                o_avm_address   <= i_cpu_addr[BYTE_AW-1:1];
                o_avm_writedata <= i_cpu_wrdata;
                is_wr           <= i_cpu_wr;
            end
            if (rd_load)
                o_cpu_rddata <= rd_val;
            if (err_set)
                o_err <= 1'b1;
            else if (i_err_clr)
                o_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus random transactions
// scored against a transaction-level model of latency, data and error flag.
module tb_mem_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_rd;
    logic        i_cpu_wr;
    logic [15:0] i_cpu_wrdata;
    logic [15:0] o_cpu_rddata;
    logic        o_cpu_stall;
    logic [14:0] o_avm_address;
    logic        o_avm_read;
    logic        o_avm_write;
    logic [15:0] o_avm_writedata;
    logic [15:0] i_avm_readdata;
    logic        i_avm_readdatavalid;
    logic        i_avm_waitrequest;
    logic        o_err;
    logic        i_err_clr;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_rddata;
    logic        m_err;

    mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_cpu_addr         (i_cpu_addr),
        .i_cpu_rd           (i_cpu_rd),
        .i_cpu_wr           (i_cpu_wr),
        .i_cpu_wrdata       (i_cpu_wrdata),
        .o_cpu_rddata       (o_cpu_rddata),
        .o_cpu_stall        (o_cpu_stall),
        .o_avm_address      (o_avm_address),
        .o_avm_read         (o_avm_read),
        .o_avm_write        (o_avm_write),
        .o_avm_writedata    (o_avm_writedata),
        .i_avm_readdata     (i_avm_readdata),
        .i_avm_readdatavalid(i_avm_readdatavalid),
        .i_avm_waitrequest  (i_avm_waitrequest),
        .o_err              (o_err),
        .i_err_clr          (i_err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One idle cycle with no request; optional error clear.
    task automatic idle_cycle(input bit clr);
        i_cpu_rd            = 1'b0;
        i_cpu_wr            = 1'b0;
        i_avm_waitrequest   = 1'b0;
        i_avm_readdatavalid = 1'($urandom_range(0, 1));
        i_avm_readdata      = 16'($urandom);
        i_err_clr           = clr;
        #1;
        chk("idle_stall", 32'(o_cpu_stall), 32'd0);
        chk("idle_strobe", 32'({o_avm_read, o_avm_write}), 32'd0);
        chk("idle_rddata", 32'(o_cpu_rddata), 32'(m_rddata));
        chk("idle_err", 32'(o_err), 32'(m_err));
        @(posedge clk);
        if (clr) m_err = 1'b0;
        @(negedge clk);
        i_err_clr           = 1'b0;
        i_avm_readdatavalid = 1'b0;
    endtask

    // One CPU access. w = cycles of waitrequest, n = cycles from accept to
    // readdatavalid (large n means the data never comes). Starts and ends on
    // a negedge; on return the request is still held (the DONE cycle).
    task automatic do_txn(input bit wr, input bit both, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] bdata,
                          input int w, input int n, input bit clr0, input bit stray);
        bit  is_wr, to, done;
        int  c, cyc, stall_n, strobe_n, acc_age, stall_exp, strobe_exp;
        is_wr = wr || both;
        c     = w + 1 + (is_wr ? 0 : n);
        to    = (c > T);
        stall_exp  = to ? T + 2 : c + 1;
        strobe_exp = to ? ((w + 1 < T) ? w + 1 : T) : w + 1;

        i_cpu_addr          = addr;
        i_cpu_wrdata        = wdata;
        i_cpu_wr            = is_wr;
        i_cpu_rd            = !wr || both;
        i_err_clr           = clr0;
        i_avm_readdatavalid = 1'b0;
        i_avm_waitrequest   = 1'b0;
        cyc = 0; stall_n = 0; strobe_n = 0; acc_age = -1; done = 1'b0;
        while (!done && cyc < 40) begin
            #1;
            if (cyc > 0 && !o_cpu_stall) begin
                done = 1'b1;
            end else begin
                if (o_cpu_stall) stall_n++;
                if (o_avm_read || o_avm_write) begin
                    strobe_n++;
                    chk("kind", 32'(o_avm_write), 32'(is_wr));
                    chk("address", 32'(o_avm_address), 32'(addr[15:1]));
                    if (is_wr) chk("writedata", 32'(o_avm_writedata), 32'(wdata));
                    i_avm_waitrequest = (strobe_n <= w);
                    if (o_avm_read && !i_avm_waitrequest) begin
                        acc_age = 0;
                        if (n == 0) begin
                            i_avm_readdatavalid = 1'b1;
                            i_avm_readdata      = bdata;
                        end
                    end else if (o_avm_write && stray) begin
                        i_avm_readdatavalid = 1'b1;
                        i_avm_readdata      = 16'($urandom);
                    end
                end else if (acc_age >= 0) begin
                    acc_age++;
                    if (acc_age == n) begin
                        i_avm_readdatavalid = 1'b1;
                        i_avm_readdata      = bdata;
                    end
                end
                @(posedge clk);
                @(negedge clk);
                i_err_clr           = 1'b0;
                i_avm_waitrequest   = 1'b0;
                i_avm_readdatavalid = 1'b0;
                cyc++;
            end
        end
        if (!done) begin
            chk("budget", 32'd0, 32'd1);
        end else begin
            if (addr[0]) m_err = 1'b1;
            else if (clr0) m_err = 1'b0;
            if (to) m_err = 1'b1;
            if (!is_wr) m_rddata = to ? 16'hDEAD : bdata;
            chk("stall_cycles", 32'(stall_n), 32'(stall_exp));
            chk("strobe_cycles", 32'(strobe_n), 32'(strobe_exp));
            chk("done_rddata", 32'(o_cpu_rddata), 32'(m_rddata));
            chk("done_err", 32'(o_err), 32'(m_err));
            chk("done_strobe", 32'({o_avm_read, o_avm_write}), 32'd0);
            // stray data in DONE must not disturb the held read data
            if (stray) begin
                i_avm_readdatavalid = 1'b1;
                i_avm_readdata      = 16'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            i_avm_readdatavalid = 1'b0;
        end
    endtask

    // Reset in the middle of a read, either in REQ or in WAIT_DATA.
    task automatic reset_mid(input bit in_wait);
        i_cpu_addr        = 16'h0222;
        i_cpu_rd          = 1'b1;
        i_cpu_wr          = 1'b0;
        i_avm_waitrequest = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        chk("rst_req_read", 32'(o_avm_read), 32'd1);
        i_avm_waitrequest = !in_wait;
        @(posedge clk); @(negedge clk);
        i_avm_waitrequest = 1'b0;
        i_cpu_rd          = 1'b0;
        #1;
        chk("rst_pre_stall", 32'(o_cpu_stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_strobe", 32'({o_avm_read, o_avm_write}), 32'd0);
        chk("rst_stall", 32'(o_cpu_stall), 32'd0);
        @(posedge clk); @(negedge clk);
        reset               = 1'b1;
        i_avm_readdatavalid = 1'b1;
        i_avm_readdata      = 16'hBEEF;
        @(posedge clk); @(negedge clk);
        i_avm_readdatavalid = 1'b0;
        #1;
        chk("rst_late_data", 32'(o_cpu_rddata), 32'd0);
        chk("rst_state_idle", 32'(o_cpu_stall), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset               = 1'b0;
        i_cpu_addr          = '0;
        i_cpu_rd            = 1'b0;
        i_cpu_wr            = 1'b0;
        i_cpu_wrdata        = '0;
        i_avm_readdata      = '0;
        i_avm_readdatavalid = 1'b0;
        i_avm_waitrequest   = 1'b0;
        i_err_clr           = 1'b0;
        m_rddata            = '0;
        m_err               = 1'b0;
        #1;
        chk("reset_strobe", 32'({o_avm_read, o_avm_write}), 32'd0);
        chk("reset_address", 32'(o_avm_address), 32'd0);
        chk("reset_wdata", 32'(o_avm_writedata), 32'd0);
        chk("reset_rddata", 32'(o_cpu_rddata), 32'd0);
        chk("reset_err", 32'(o_err), 32'd0);
        chk("reset_stall_lo", 32'(o_cpu_stall), 32'd0);
        i_cpu_rd = 1'b1;
        #1;
        chk("reset_stall_hi", 32'(o_cpu_stall), 32'd1);
        i_cpu_rd = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        reset_mid(1'b0);
        reset_mid(1'b1);

        do_txn(1, 0, 16'h0040, 16'h1234, 16'h0000, 0, 0, 0, 0);
        idle_cycle(0);
        do_txn(0, 0, 16'h0100, 16'h0000, 16'hBEEF, 3, 2, 0, 0);
        idle_cycle(0);
        do_txn(0, 0, 16'h0200, 16'h0000, 16'hA5A5, 0, 0, 0, 1);
        do_txn(0, 0, 16'h0300, 16'h0000, 16'h5A5A, 1, 0, 0, 0);
        idle_cycle(0);
        do_txn(0, 0, 16'h0400, 16'h0000, 16'h1111, 0, 99, 0, 0);
        idle_cycle(0);
        idle_cycle(0);
        idle_cycle(1);
        idle_cycle(0);
        do_txn(0, 1, 16'h0003, 16'hCAFE, 16'h0000, 0, 0, 0, 0);
        idle_cycle(1);
        do_txn(1, 0, 16'h0010, 16'h7777, 16'h0000, 100, 0, 0, 0);
        idle_cycle(1);
        // clear and misaligned set in the same cycle: set wins
        do_txn(0, 0, 16'h0011, 16'h0000, 16'h2222, 0, 1, 1, 0);
        idle_cycle(1);

        for (int i = 0; i < 60; i++) begin
            bit wr, both, clr0, stray;
            int w, n;
            logic [15:0] addr;
            wr    = 1'($urandom_range(0, 1));
            both  = ($urandom_range(0, 7) == 0);
            clr0  = ($urandom_range(0, 3) == 0);
            stray = 1'($urandom_range(0, 1));
            w     = $urandom_range(0, 3);
            n     = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
            addr  = 16'($urandom);
            if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
            do_txn(wr, both, addr, 16'($urandom), 16'($urandom), w, n, clr0, stray);
            if ($urandom_range(0, 2) != 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
